// File: rtl/parall_rsp_pkg.sv
// Shared definitions for the parall_rsp host parallel-bus responder.
package parall_pkg;

  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned SYNC_STG_DEF = 2;

  // Read-only write-counter address (used only with PARALL_RSP_WRCNT_EN).
  localparam logic [7:0] CNT_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    WR_ACT,
    RD_ACT,
    ERR
  } bus_st_e;

  // Classify the synchronized strobes into a bus state.
  function automatic bus_st_e bus_decode(input logic cs_s, input logic rd_s,
                                         input logic wr_s);
    bus_st_e st;
    st = IDLE;
    if (!cs_s) begin
      if (!rd_s && !wr_s) st = ERR;
      else if (!wr_s)     st = WR_ACT;
      else if (!rd_s)     st = RD_ACT;
    end
    return st;
  endfunction

endpackage

// File: rtl/parall_rsp_if.sv
// Host parallel-bus control/address signals (responder side is the slave).
// The bidirectional data bus is a plain inout port on parall_rsp.
interface parall_rsp_if
  import parall_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              cs_n;
  logic              rd_n;
  logic              wr_n;
  logic [ADDR_W-1:0] addr;

  modport master (output cs_n, rd_n, wr_n, addr);
  modport slave  (input  cs_n, rd_n, wr_n, addr);
endinterface

// File: rtl/parall_rsp_sync.sv
// N-stage synchronizer for a bundle of strobes, plus one delay flop so that
// rise/fall pulses are formed purely from registered values.
module parall_sync #(
  parameter int unsigned N       = 2,
  parameter int unsigned W       = 3,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_stg [N];
  logic [W-1:0] r_dly;

  // Synchronizer chain followed by the edge-detect delay flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < N; i++) r_stg[i] <= RST_VAL;
      r_dly <= RST_VAL;
    end else begin
      r_stg[0] <= i_d;
      for (int unsigned i = 1; i < N; i++) r_stg[i] <= r_stg[i-1];
      r_dly <= r_stg[N-1];
    end
  end

  assign o_q    = r_stg[N-1];
  assign o_rise = r_stg[N-1] & ~r_dly;
  assign o_fall = ~r_stg[N-1] & r_dly;

endmodule

// File: rtl/parall_rsp.sv
// Responder for the asynchronous host parallel bus: synchronizes strobes,
// commits host writes to a register file, and drives read data back.
// Optional build macro PARALL_RSP_WRCNT_EN adds a saturating committed-write
// counter readable at CNT_ADDR (writes to that address are ignored).
module parall_rsp
  import parall_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned SYNC_STG = SYNC_STG_DEF
) (
  input  logic              sclk,
  input  logic              rst,
  parall_rsp_if.slave       bus,
  inout  wire  [DATA_W-1:0] data,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_dat,
  output logic              proto_err
);

  logic [2:0]        w_stb_s;
  logic [2:0]        w_stb_rise;
  logic [2:0]        w_stb_fall;
  logic              w_cs_s;
  logic              w_rd_s;
  logic              w_wr_s;
  logic              w_wr_rise;
  logic              w_rd_fall;
  logic              w_unused;
  logic              w_oe;
  logic              w_commit;
  logic              w_capture;
  bus_st_e           w_bus_nxt;
  logic [ADDR_W-1:0] w_addr_s;
  logic [DATA_W-1:0] w_data_s;
  logic [DATA_W-1:0] w_rd_src;

  bus_st_e           r_state;
  logic [ADDR_W-1:0] r_addr_stg [SYNC_STG];
  logic [DATA_W-1:0] r_data_stg [SYNC_STG];
  logic [ADDR_W-1:0] r_addr_cap;
  logic [DATA_W-1:0] r_data_cap;
  logic [DATA_W-1:0] r_rd_dat;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  parall_sync #(
    .N      (SYNC_STG),
    .W      (3),
    .RST_VAL(3'b111)
  ) u_sync (
    .i_clk (sclk),
    .i_rst (rst),
    .i_d   ({bus.cs_n, bus.rd_n, bus.wr_n}),
    .o_q   (w_stb_s),
    .o_rise(w_stb_rise),
    .o_fall(w_stb_fall)
  );

  assign w_cs_s    = w_stb_s[2];
  assign w_rd_s    = w_stb_s[1];
  assign w_wr_s    = w_stb_s[0];
  assign w_wr_rise = w_stb_rise[0];
  assign w_rd_fall = w_stb_fall[1];
  assign w_unused  = ^{w_stb_rise[2:1], w_stb_fall[2], w_stb_fall[0]};

  // Plain synchronizer stages for address and data.
  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STG; i++) begin
        r_addr_stg[i] <= '0;
        r_data_stg[i] <= '0;
      end
    end else begin
      r_addr_stg[0] <= bus.addr;
      r_data_stg[0] <= data;
      for (int unsigned i = 1; i < SYNC_STG; i++) begin
        r_addr_stg[i] <= r_addr_stg[i-1];
        r_data_stg[i] <= r_data_stg[i-1];
      end
    end
  end

  assign w_addr_s = r_addr_stg[SYNC_STG-1];
  assign w_data_s = r_data_stg[SYNC_STG-1];

  // Next bus state; ERR persists until wr or cs releases so a write strobe
  // that overlapped a read strobe can never turn into a commit.
  always_comb begin
    w_bus_nxt = bus_decode(w_cs_s, w_rd_s, w_wr_s);
    if (r_state == ERR && !w_cs_s && !w_wr_s) w_bus_nxt = ERR;
  end

  assign w_capture = (w_bus_nxt == WR_ACT);

`ifdef PARALL_RSP_WRCNT_EN
  logic [15:0] r_wr_cnt;

  assign w_commit = w_wr_rise && (r_state == WR_ACT) &&
                    (r_addr_cap != ADDR_W'(CNT_ADDR));

  always_comb begin
    w_rd_src = r_mem[w_addr_s];
    if (w_addr_s == ADDR_W'(CNT_ADDR)) w_rd_src = DATA_W'(r_wr_cnt);
  end

  // Saturating count of committed writes.
  always_ff @(posedge sclk) begin
    if (rst)                           r_wr_cnt <= '0;
    else if (w_commit && r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 16'd1;
  end
`else
  assign w_commit = w_wr_rise && (r_state == WR_ACT);

  always_comb begin
    w_rd_src = r_mem[w_addr_s];
  end
`endif

  // Bus-state FSM, write capture/commit reporting, read load, error flag.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr_cap <= '0;
      r_data_cap <= '0;
      r_rd_dat   <= '0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_dat     <= '0;
      proto_err  <= 1'b0;
    end else begin
      r_state <= w_bus_nxt;
      if (w_capture) begin
        r_addr_cap <= w_addr_s;
        r_data_cap <= w_data_s;
      end
      wr_stb <= w_commit;
      if (w_commit) begin
        wr_addr <= r_addr_cap;
        wr_dat  <= r_data_cap;
      end
      if (w_rd_fall && !w_cs_s && w_wr_s) r_rd_dat <= w_rd_src;
      if (!w_cs_s && !w_rd_s && !w_wr_s) proto_err <= 1'b1;
    end
  end

  // Register file write port; contents are deliberately not reset.
  always_ff @(posedge sclk) begin
    if (!rst && w_commit) r_mem[r_addr_cap] <= r_data_cap;
  end

  assign w_oe = ~w_cs_s & ~w_rd_s & w_wr_s;
  assign data = w_oe ? r_rd_dat : 'z;

endmodule

// File: tb/tb_parall_rsp.sv
// Directed bench for parall_rsp. The data bus is pulled up, so an undriven
// bus reads as 16'hFFFF.
module tb_parall_rsp;
  import parall_pkg::*;

  logic        sclk = 1'b0;
  logic        rst  = 1'b1;
  tri1  [15:0] data;
  logic        drv_en  = 1'b0;
  logic [15:0] drv_dat = '0;
  logic        wr_stb;
  logic [7:0]  wr_addr;
  logic [15:0] wr_dat;
  logic        proto_err;

  int n_vec  = 0;
  int n_miss = 0;
  int stb_cnt = 0;
  logic [15:0] rd_val;
  int stb_base;

  parall_rsp_if #(.ADDR_W(8)) bus_if ();

  parall_rsp #(
    .ADDR_W  (8),
    .DATA_W  (16),
    .SYNC_STG(2)
  ) dut (
    .sclk     (sclk),
    .rst      (rst),
    .bus      (bus_if.slave),
    .data     (data),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_dat   (wr_dat),
    .proto_err(proto_err)
  );

  assign data = drv_en ? drv_dat : 'z;

  always #10 sclk = ~sclk;

  always @(posedge sclk) if (wr_stb === 1'b1) stb_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [15:0] d,
                            input logic keep_cs);
    bus_if.addr = a;
    drv_dat     = d;
    drv_en      = 1'b1;
    bus_if.cs_n = 1'b0;
    tick(2);
    bus_if.wr_n = 1'b0;
    tick(4);
    bus_if.wr_n = 1'b1;
    tick(2);
    drv_en = 1'b0;
    if (!keep_cs) bus_if.cs_n = 1'b1;
    tick(3);
  endtask

  task automatic host_read(input logic [7:0] a, output logic [15:0] d);
    bus_if.addr = a;
    bus_if.cs_n = 1'b0;
    tick(2);
    bus_if.rd_n = 1'b0;
    tick(4);
    d = data;
    bus_if.rd_n = 1'b1;
    bus_if.cs_n = 1'b1;
    tick(3);
  endtask

  initial begin
    bus_if.cs_n = 1'b1;
    bus_if.rd_n = 1'b1;
    bus_if.wr_n = 1'b1;
    bus_if.addr = '0;
    tick(3);
    check("rst_wr_stb", 32'(wr_stb), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_dat", 32'(wr_dat), 32'h0);
    check("rst_proto_err", 32'(proto_err), 32'h0);
    check("rst_data_z", 32'(data), 32'hFFFF);
    rst = 1'b0;
    tick(2);

    // Eight writes, addr i = data i.
    for (int i = 0; i < 8; i++) host_write(8'(i), 16'(i), 1'b0);
    check("wr8_stb_count", 32'(stb_cnt), 32'd8);
    check("wr8_wr_addr", 32'(wr_addr), 32'd7);
    check("wr8_wr_dat", 32'(wr_dat), 32'd7);

    // Read back, bus released between reads.
    for (int i = 0; i < 8; i++) begin
      host_read(8'(i), rd_val);
      check($sformatf("rd_addr%0d", i), 32'(rd_val), 32'(i));
      check($sformatf("rd_gap_z%0d", i), 32'(data), 32'hFFFF);
    end

`ifdef PARALL_RSP_WRCNT_EN
    stb_base = stb_cnt;
    host_write(8'hFF, 16'h1234, 1'b0);
    check("cnt_wr_ignored_stb", 32'(stb_cnt), 32'(stb_base));
    host_read(8'hFF, rd_val);
    check("cnt_read", 32'(rd_val), 32'd8);
`else
    stb_base = stb_cnt;
    host_write(8'hFF, 16'h1234, 1'b0);
    check("top_addr_stb", 32'(stb_cnt), 32'(stb_base + 1));
    check("top_addr_wr_addr", 32'(wr_addr), 32'hFF);
    host_read(8'hFF, rd_val);
    check("top_addr_read", 32'(rd_val), 32'h1234);
`endif

    // cs_n drops mid-write: no commit.
    stb_base = stb_cnt;
    bus_if.addr = 8'd3;
    drv_dat     = 16'hBEEF;
    drv_en      = 1'b1;
    bus_if.cs_n = 1'b0;
    tick(2);
    bus_if.wr_n = 1'b0;
    tick(4);
    bus_if.cs_n = 1'b1;
    tick(2);
    bus_if.wr_n = 1'b1;
    tick(4);
    drv_en = 1'b0;
    check("abort_no_stb", 32'(stb_cnt), 32'(stb_base));
    host_read(8'd3, rd_val);
    check("abort_read3", 32'(rd_val), 32'd3);

    // Back-to-back writes with cs_n held low.
    stb_base = stb_cnt;
    host_write(8'd10, 16'hA5A5, 1'b1);
    host_write(8'd11, 16'h5A5A, 1'b0);
    check("b2b_stb", 32'(stb_cnt), 32'(stb_base + 2));
    host_read(8'd10, rd_val);
    check("b2b_read10", 32'(rd_val), 32'hA5A5);
    host_read(8'd11, rd_val);
    check("b2b_read11", 32'(rd_val), 32'h5A5A);

    // rd_n and wr_n low together: protocol error, no drive, no commit.
    stb_base = stb_cnt;
    check("pre_proto_err", 32'(proto_err), 32'h0);
    bus_if.addr = 8'd4;
    bus_if.cs_n = 1'b0;
    tick(2);
    bus_if.rd_n = 1'b0;
    bus_if.wr_n = 1'b0;
    tick(4);
    check("proto_err_set", 32'(proto_err), 32'h1);
    check("proto_data_z", 32'(data), 32'hFFFF);
    bus_if.rd_n = 1'b1;
    bus_if.wr_n = 1'b1;
    tick(4);
    bus_if.cs_n = 1'b1;
    tick(2);
    check("proto_no_stb", 32'(stb_cnt), 32'(stb_base));
    host_read(8'd4, rd_val);
    check("proto_read4", 32'(rd_val), 32'd4);
    check("proto_err_sticky", 32'(proto_err), 32'h1);

    // Reset during an active read.
    bus_if.addr = 8'd5;
    bus_if.cs_n = 1'b0;
    tick(2);
    bus_if.rd_n = 1'b0;
    tick(4);
    check("pre_rst_read", 32'(data), 32'd5);
    rst = 1'b1;
    tick(1);
    check("rst_mid_data_z", 32'(data), 32'hFFFF);
    check("rst_mid_wr_stb", 32'(wr_stb), 32'h0);
    check("rst_mid_proto_err", 32'(proto_err), 32'h0);
    check("rst_mid_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_mid_wr_dat", 32'(wr_dat), 32'h0);
    rst = 1'b0;
    bus_if.rd_n = 1'b1;
    bus_if.cs_n = 1'b1;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/parall_rsp.md
Name: parall_rsp

Overview:
- Synthesizable responder (slave) for the asynchronous host parallel bus: cs_n, rd_n, wr_n, addr[7:0], data[15:0] bidirectional.
- Synchronizes the bus strobes into the sclk domain and commits host writes into a 256x16 register file.
- Returns register contents on host reads by driving the shared data bus.
- Sits at the FPGA edge, between the external host/MCU and internal control logic.

Parameters:
- ADDR_W, 8, bus address width; register file depth is 2**ADDR_W.
- DATA_W, 16, bus and register data width.
- SYNC_STG, 2, synchronizer flops on cs_n/rd_n/wr_n/addr/data; legal values 2..3.

Ports:
- sclk  in  1  system clock (50 MHz nominal).
- rst  in  1  synchronous reset, active-high.
- cs_n  in  1  host chip select, active-low, asynchronous.
- rd_n  in  1  host read strobe, active-low, asynchronous.
- wr_n  in  1  host write strobe, active-low, asynchronous.
- addr  in  ADDR_W  host address, asynchronous.
- data  inout  DATA_W  shared data bus; driven only during a valid read, else high-Z.
- wr_stb  out  1  one-cycle pulse when a write commits.
- wr_addr  out  ADDR_W  address of the last committed write.
- wr_dat  out  DATA_W  data of the last committed write.
- proto_err  out  1  sticky flag: rd_n and wr_n both sampled low under cs_n low; cleared only by rst.

Behaviour:
- Clocking and reset: one clock, sclk. Reset is synchronous and active-high on rst.
- Reset values:
  - Synchronizer flops for cs_n/rd_n/wr_n = 1; for addr/data = 0.
  - wr_stb = 0, wr_addr = 0, wr_dat = 0, proto_err = 0.
  - Output enable = 0, so data is high-Z.
  - Register file contents are not reset.
- Synchronization: all bus inputs pass through SYNC_STG flops, giving cs_s, rd_s, wr_s, addr_s, data_s. One further flop on rd_s/wr_s provides edge detection.
- Write capture:
  - While cs_s=0 and wr_s=0 (and rd_s=1), load data_cap<=data_s and addr_cap<=addr_s every cycle.
  - On wr_s rising edge (0->1), and only if the write was held under cs_s=0, commit: mem[addr_cap]<=data_cap.
  - In the same cycle, assert wr_stb for exactly 1 cycle and update wr_addr/wr_dat.
  - The host releases data when wr_n rises; the last sample taken while low is the one that commits.
- Read:
  - On rd_s falling edge with cs_s=0 and wr_s=1, load rd_reg<=mem[addr_s].
  - Output enable oe = ~cs_s & ~rd_s & wr_s. data = oe ? rd_reg : Z.
  - Latency: rd_n low to data valid within SYNC_STG+1 sclk edges (3 at default). Host must hold rd_n low for at least 4 clocks.
  - oe drops SYNC_STG cycles after rd_n or cs_n rises.
- Minimum strobe width: write low time must be at least SYNC_STG+1 clocks. Shorter strobes are undefined.
- Boundary conditions:
  - rd_s=0 and wr_s=0 together under cs_s=0: no commit, oe=0, proto_err<=1.
  - cs_s rises mid-write: abort; no commit on the later wr_s rise.
  - Back-to-back writes with cs_n held low: each wr_n rise commits independently.
  - Write to address 2**ADDR_W-1: normal, no wrap side effects.
  - rst mid-transfer: oe=0 the next cycle; a pending commit is discarded.

Optional Feature:
- Macro: PARALL_RSP_WRCNT_EN.
- Defined:
  - 16-bit saturating counter of committed writes.
  - Address CNT_ADDR (8'hFF) is read-only: reads return the counter; writes to it are ignored (no mem update, no wr_stb, no count).
  - Counter resets to 0.
- Undefined: 8'hFF is an ordinary register; no counter logic is present.

Decomposition:
- Package parall_pkg:
  - ADDR_W/DATA_W defaults.
  - CNT_ADDR = 8'hFF.
  - Bus-state enum: IDLE, WR_ACT, RD_ACT, ERR.
- Sub-module parall_sync: N-stage synchronizer with registered rise/fall pulses. Instantiated once for the 3 strobes (bus width param); addr/data use plain stage flops.

Test Plan:
- Write 8 words, addr i = data i (i=0..7): 2-clock setup, wr_n low 4 clocks, 2-clock hold -> 8 wr_stb pulses; wr_addr/wr_dat = 7/7 after the last.
- Read back addr 0..7 with rd_n low 4 clocks, sampling at the end -> data = 0..7; data is Z between reads.
- Drop cs_n high while wr_n is low, then wr_n rises (addr 3, data 16'hBEEF) -> no wr_stb; a read of addr 3 still returns 3.
- Drive rd_n and wr_n low together with cs_n low -> proto_err=1, data stays Z, no commit; proto_err stays 1 until rst.
- Assert rst for 1 cycle during an active read -> data Z the next cycle; wr_stb, proto_err, wr_addr and wr_dat all 0.
- With PARALL_RSP_WRCNT_EN defined: 8 writes, then a write to 8'hFF, then a read of 8'hFF -> returns 16'd8.
